// File: rtl/fifo_stream_drain_pkg.sv
// Shared types and constants for the FIFO read-side stream drain.
package fifo_stream_drain_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } drain_state_e;

   localparam int          DRAIN_BUF_DEPTH = 2;
   localparam int unsigned PERF_CNT_W      = 16;

endpackage : fifo_stream_drain_pkg

// File: rtl/fifo_stream_drain.sv
// Drains a sync FIFO into a valid/ready stream through a 2-entry skid buffer.
// Optional FIFO_STREAM_PERF_EN adds saturating stall/starve counters.
module fifo_stream_drain
   import fifo_stream_drain_pkg::*;
#(
   parameter int unsigned FIFO_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   output logic [FIFO_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic                  err_underflow
`ifdef FIFO_STREAM_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] stall_cnt,
   output logic [PERF_CNT_W-1:0] starve_cnt
`endif
);

   drain_state_e          r_state;
   logic                  r_inflight;
   logic                  r_err_underflow;
   logic [FIFO_WIDTH-1:0] r_entry0;
   logic [FIFO_WIDTH-1:0] r_entry1;

   logic                  w_pop;
   logic                  w_push;
   logic [2:0]            w_occ;
   logic [2:0]            w_credit;

   assign m_valid       = !rst && (r_state != S_EMPTY);
   assign m_data        = rst ? '0 : r_entry0;
   assign err_underflow = r_err_underflow;

   assign w_pop    = m_valid & m_ready;
   assign w_push   = r_inflight & !fifo_underflow & !flush;
   assign w_occ    = {1'b0, r_state};
   // Slots committed after this edge: buffered words plus the returning read, minus the pop.
   assign w_credit = w_occ + {2'b00, r_inflight} - {2'b00, w_pop};

   assign fifo_rd_en = !rst && !flush && !fifo_empty && (w_credit < 3'(DRAIN_BUF_DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_EMPTY;
         r_inflight      <= 1'b0;
         r_err_underflow <= 1'b0;
         r_entry0        <= '0;
         r_entry1        <= '0;
      end else begin
         r_inflight <= fifo_rd_en;
         if (r_inflight && fifo_underflow) begin
            r_err_underflow <= 1'b1;
         end
         if (flush) begin
            r_state  <= S_EMPTY;
            r_entry0 <= '0;
            r_entry1 <= '0;
         end else begin
            case (r_state)
               S_EMPTY: begin
                  if (w_push) begin
                     r_entry0 <= fifo_data_out;
                     r_state  <= S_ONE;
                  end
               end
               S_ONE: begin
                  if (w_push && w_pop) begin
                     r_entry0 <= fifo_data_out;
                  end else if (w_push) begin
                     r_entry1 <= fifo_data_out;
                     r_state  <= S_TWO;
                  end else if (w_pop) begin
                     r_state  <= S_EMPTY;
                  end
               end
               S_TWO: begin
                  if (w_pop) begin
                     r_entry0 <= r_entry1;
                     if (w_push) begin
                        r_entry1 <= fifo_data_out;
                     end else begin
                        r_state <= S_ONE;
                     end
                  end
               end
               default: r_state <= S_EMPTY;
            endcase
         end
      end
   end

`ifdef FIFO_STREAM_PERF_EN
   logic [PERF_CNT_W-1:0] r_stall_cnt;
   logic [PERF_CNT_W-1:0] r_starve_cnt;

   // Saturating counters; flush deliberately leaves them untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_starve_cnt <= '0;
      end else begin
         if (m_valid && !m_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + PERF_CNT_W'(1);
         end
         if (!m_valid && fifo_empty && (r_starve_cnt != '1)) begin
            r_starve_cnt <= r_starve_cnt + PERF_CNT_W'(1);
         end
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign starve_cnt = r_starve_cnt;
`endif

   a_credit: assert property (@(posedge clk) disable iff (rst)
      (w_occ + {2'b00, r_inflight}) <= 3'(DRAIN_BUF_DEPTH));

   a_no_push_full: assert property (@(posedge clk) disable iff (rst)
      !(w_push && (r_state == S_TWO)));

   a_data_stable: assert property (@(posedge clk) disable iff (rst)
      (m_valid && !m_ready && !flush) |=> $stable(m_data));

   a_no_rd_empty: assert property (@(posedge clk)
      !(fifo_rd_en && fifo_empty));

endmodule : fifo_stream_drain

// File: tb/tb_fifo_stream_drain.sv
// Self-checking bench for fifo_stream_drain: behavioural sync-FIFO model plus stream scoreboard.
module tb_fifo_stream_drain;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic         m_ready = 1'b0;
   logic         fifo_empty = 1'b1;
   logic         fifo_underflow = 1'b0;
   logic [W-1:0] fifo_data_out = '0;
   logic         fifo_rd_en;
   logic         m_valid;
   logic [W-1:0] m_data;
   logic         err_underflow;
`ifdef FIFO_STREAM_PERF_EN
   logic [15:0]  stall_cnt;
   logic [15:0]  starve_cnt;
`endif

   int           checks = 0;
   int           errors = 0;

   logic [W-1:0] fq[$];
   logic [W-1:0] got[$];
   bit           force_uf = 1'b0;
   int           n_reads = 0;
   int           n_pops = 0;
   int           max_out = 0;
   int           stab_err = 0;
   bit           hold_prev = 1'b0;
   logic [W-1:0] hold_data = '0;

   always #5 clk = ~clk;

   fifo_stream_drain #(.FIFO_WIDTH(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .fifo_data_out  (fifo_data_out),
      .fifo_rd_en     (fifo_rd_en),
      .m_valid        (m_valid),
      .m_data         (m_data),
      .m_ready        (m_ready),
      .err_underflow  (err_underflow)
`ifdef FIFO_STREAM_PERF_EN
      ,
      .stall_cnt      (stall_cnt),
      .starve_cnt     (starve_cnt)
`endif
   );

   // Sync FIFO: data/underflow valid the cycle after rd_en; empty follows the contents.
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         if (force_uf || fq.size() == 0) begin
            fifo_underflow <= 1'b1;
         end else begin
            fifo_data_out  <= fq.pop_front();
            fifo_underflow <= 1'b0;
         end
      end else begin
         fifo_underflow <= 1'b0;
      end
      fifo_empty <= (fq.size() == 0);
   end

   // Stream monitor: accepted beats, read/pop balance, hold stability.
   always @(posedge clk) begin
      if (rst) begin
         n_reads   = 0;
         n_pops    = 0;
         max_out   = 0;
         stab_err  = 0;
         hold_prev = 1'b0;
         got.delete();
      end else begin
         if (hold_prev && !(m_valid && m_data == hold_data)) stab_err++;
         if (fifo_rd_en) n_reads++;
         if (m_valid && m_ready && !flush) begin
            n_pops++;
            got.push_back(m_data);
         end
         if (n_reads - n_pops > max_out) max_out = n_reads - n_pops;
         hold_prev = m_valid && !m_ready && !flush;
         hold_data = m_data;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      flush    = 1'b0;
      m_ready  = 1'b0;
      force_uf = 1'b0;
      fq.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      fq.push_back(16'hABCD);
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b expected 0", fifo_rd_en); end
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b expected 0", m_valid); end
      checks++;
      if (m_data !== 16'h0000) begin errors++; $display("FAIL reset_m_data got %h expected 0000", m_data); end
      checks++;
      if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", err_underflow); end
`ifdef FIFO_STREAM_PERF_EN
      checks++;
      if (stall_cnt !== 16'd0 || starve_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_perf got %0d/%0d expected 0/0", stall_cnt, starve_cnt);
      end
`endif
      do_reset();
   endtask

   task automatic test_streaming();
      int first_rd = -1;
      int first_v  = -1;
      int run      = 0;
      int best     = 0;
      do_reset();
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) fq.push_back(W'(i));
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         #1;
         if (fifo_rd_en && first_rd < 0) first_rd = c;
         if (m_valid) begin
            if (first_v < 0) first_v = c;
            run++;
            if (run > best) best = run;
         end else begin
            run = 0;
         end
      end
      checks++;
      if (first_v - first_rd != 2) begin
         errors++; $display("FAIL stream_latency got %0d expected 2", first_v - first_rd);
      end
      checks++;
      if (best != 8) begin errors++; $display("FAIL stream_beats got %0d expected 8", best); end
      checks++;
      if (got.size() != 8) begin errors++; $display("FAIL stream_count got %0d expected 8", got.size()); end
      for (int i = 0; i < got.size() && i < 8; i++) begin
         checks++;
         if (got[i] !== W'(i + 1)) begin
            errors++; $display("FAIL stream_data[%0d] got %h expected %h", i, got[i], W'(i + 1));
         end
      end
      checks++;
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL stream_rd_idle got %b expected 0", fifo_rd_en); end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      do_reset();
      m_ready = 1'b0;
      for (int i = 1; i <= 4; i++) fq.push_back(W'(i));
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         #1;
         if (m_valid && m_data !== 16'h0001) bad++;
      end
      checks++;
      if (n_reads != 2) begin errors++; $display("FAIL bp_reads got %0d expected 2", n_reads); end
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h0001) begin
         errors++; $display("FAIL bp_head got %b/%h expected 1/0001", m_valid, m_data);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d changes expected 0", bad); end
`ifdef FIFO_STREAM_PERF_EN
      checks++;
      if (stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall_cnt got %0d expected 3", stall_cnt); end
`endif
      m_ready = 1'b1;
      for (int c = 0; c < 20 && got.size() < 4; c++) @(negedge clk);
      checks++;
      if (got.size() != 4) begin errors++; $display("FAIL bp_count got %0d expected 4", got.size()); end
      for (int i = 0; i < got.size() && i < 4; i++) begin
         checks++;
         if (got[i] !== W'(i + 1)) begin
            errors++; $display("FAIL bp_data[%0d] got %h expected %h", i, got[i], W'(i + 1));
         end
      end
   endtask

   task automatic test_alt_ready();
      logic [W-1:0] exp_q[$];
      do_reset();
      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] w;
         w = W'($urandom);
         fq.push_back(w);
         exp_q.push_back(w);
      end
      for (int c = 0; c < 60 && got.size() < 6; c++) begin
         @(negedge clk);
         m_ready = (c % 2 == 0);
      end
      checks++;
      if (got.size() != 6) begin errors++; $display("FAIL alt_count got %0d expected 6", got.size()); end
      for (int i = 0; i < got.size() && i < 6; i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++; $display("FAIL alt_data[%0d] got %h expected %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (max_out > 2) begin errors++; $display("FAIL alt_occ got %0d expected <=2", max_out); end
      checks++;
      if (stab_err != 0) begin errors++; $display("FAIL alt_stable got %0d expected 0", stab_err); end
   endtask

   task automatic test_random();
      logic [W-1:0] exp_q[$];
      int total  = 48;
      int loaded = 0;
      int diffs  = 0;
      do_reset();
      for (int c = 0; c < 800 && got.size() < total; c++) begin
         @(negedge clk);
         if (loaded < total && $urandom_range(0, 2) == 0) begin
            int n = $urandom_range(1, 3);
            for (int k = 0; k < n && loaded < total; k++) begin
               logic [W-1:0] w;
               w = W'($urandom);
               fq.push_back(w);
               exp_q.push_back(w);
               loaded++;
            end
         end
         m_ready = ($urandom_range(0, 3) != 0);
      end
      checks++;
      if (got.size() != total) begin errors++; $display("FAIL rand_count got %0d expected %0d", got.size(), total); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         if (got[i] !== exp_q[i]) diffs++;
      end
      checks++;
      if (diffs != 0) begin errors++; $display("FAIL rand_order got %0d wrong words expected 0", diffs); end
      checks++;
      if (max_out > 2) begin errors++; $display("FAIL rand_occ got %0d expected <=2", max_out); end
      checks++;
      if (stab_err != 0) begin errors++; $display("FAIL rand_stable got %0d expected 0", stab_err); end
   endtask

   task automatic test_flush();
      do_reset();
      m_ready = 1'b0;
      for (int i = 1; i <= 5; i++) fq.push_back(W'(16'h0010 + i));
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h0011) begin
         errors++; $display("FAIL flush_pre got %b/%h expected 1/0011", m_valid, m_data);
      end
      m_ready = 1'b1;
      #1;
      checks++;
      if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL flush_credit_rd got %b expected 1", fifo_rd_en); end
      @(negedge clk);
      m_ready = 1'b0;
      flush   = 1'b1;
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL flush_rd_en got %b expected 0", fifo_rd_en); end
      @(negedge clk);
      flush = 1'b0;
      #1;
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b expected 0", m_valid); end
      m_ready = 1'b1;
      for (int c = 0; c < 20; c++) @(negedge clk);
      checks++;
      if (got.size() != 3) begin errors++; $display("FAIL flush_count got %0d expected 3", got.size()); end
      else begin
         checks++;
         if (got[0] !== 16'h0011 || got[1] !== 16'h0014 || got[2] !== 16'h0015) begin
            errors++; $display("FAIL flush_data got %h %h %h expected 0011 0014 0015", got[0], got[1], got[2]);
         end
      end
   endtask

   task automatic test_underflow();
      do_reset();
      m_ready = 1'b1;
      fq.push_back(16'h0021);
      fq.push_back(16'h0022);
      force_uf = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (force_uf && fifo_underflow) force_uf = 1'b0;
         #1;
         if (c == 3) begin
            checks++;
            if (m_valid !== 1'b0) begin errors++; $display("FAIL uf_drop got %b expected 0", m_valid); end
         end
      end
      checks++;
      if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_err got %b expected 1", err_underflow); end
      checks++;
      if (got.size() != 2) begin errors++; $display("FAIL uf_count got %0d expected 2", got.size()); end
      else begin
         checks++;
         if (got[0] !== 16'h0021 || got[1] !== 16'h0022) begin
            errors++; $display("FAIL uf_data got %h %h expected 0021 0022", got[0], got[1]);
         end
      end
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_err_flush got %b expected 1", err_underflow); end
      rst = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_err_rst got %b expected 0", err_underflow); end
      rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) fq.push_back(W'(16'h0100 + i));
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (m_valid !== 1'b0 || m_data !== 16'h0000) begin
         errors++; $display("FAIL rstmid_out got %b/%h expected 0/0000", m_valid, m_data);
      end
      checks++;
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en got %b expected 0", fifo_rd_en); end
      checks++;
      if (err_underflow !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b expected 0", err_underflow); end
`ifdef FIFO_STREAM_PERF_EN
      checks++;
      if (stall_cnt !== 16'd0 || starve_cnt !== 16'd0) begin
         errors++; $display("FAIL rstmid_perf got %0d/%0d expected 0/0", stall_cnt, starve_cnt);
      end
`endif
      do_reset();
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_alt_ready();
      test_random();
      test_flush();
      test_underflow();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout after %0d checks", checks);
      $fatal(1);
   end

endmodule : tb_fifo_stream_drain
